guess_history_buf: RTL and testbench
====================================

Name: guess_history_buf

Overview:
- Parametrised guess/feedback history buffer for the Mastermind datapath; successor to the fixed 4-peg, 8-turn history store.
- Records each submitted guess together with its black/white feedback.
- In guess mode it reports the newest entry; in browse mode it lets the player step through entries with up/down.
- Sits between the guess-entry/feedback logic and the display driver, and supplies full and last-turn status to the game controller.

Parameters:
- NUM_PEGS, 4, pegs per guess
- PEG_W, 3, bits per peg colour
- DEPTH, 8, maximum stored turns (≥2)
- FB_W, 3, width of each feedback count (black, white)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mode  in  1  0 = guess mode, 1 = browse mode
- store  in  1  one-cycle pulse: commit guess_in/fb_black_in/fb_white_in
- guess_in  in  NUM_PEGS*PEG_W  current guess, peg 0 in LSBs
- fb_black_in  in  FB_W  exact-match count for guess_in
- fb_white_in  in  FB_W  colour-only-match count for guess_in
- btn_up  in  1  one-cycle pulse (already debounced): select the next-newer entry
- btn_down  in  1  one-cycle pulse: select the next-older entry
- sel_guess  out  NUM_PEGS*PEG_W  guess at sel_idx
- sel_black  out  FB_W  black count at sel_idx
- sel_white  out  FB_W  white count at sel_idx
- sel_idx  out  IDX_W=$clog2(DEPTH)  turn number being shown
- count  out  CNT_W=$clog2(DEPTH+1)  number of stored entries
- sel_valid  out  1  sel_* outputs hold a real entry
- full  out  1  count == DEPTH
- last_turn  out  1  count == DEPTH-1 (the next store is the final turn)
- store_err  out  1  one-cycle pulse: a store was rejected

Behaviour:
- Reset values: count=0, sel_idx=0, all sel_* outputs 0, sel_valid=0, full=0, last_turn=0, store_err=0. Memory contents need not be cleared; sel_valid gates their use.
- Storage is a DEPTH-entry register array. Entry = {guess, black, white}, W = NUM_PEGS*PEG_W + 2*FB_W.
- Store, accepted only when mode=0 and !full:
  - At the edge: mem[count] <= entry, count <= count+1, sel_idx <= count (old value).
  - sel_guess/sel_black/sel_white show the new entry one cycle later (registered read).
- Rejected store (mode=1, or full): memory, count and sel_idx are unchanged; store_err pulses high for one cycle on the next edge.
- Read path: sel_* <= mem[sel_idx] on every edge, so latency is 1 cycle from any sel_idx change; sel_valid <= (count != 0).
- count == 0: sel_* are forced to 0 and sel_valid=0 in both modes.
- Guess mode, no store: sel_idx is held at count-1, or 0 when empty.
- Entering browse mode (mode 0→1): sel_idx starts at count-1, the newest entry.
- Browse mode navigation:
  - btn_up: sel_idx+1, saturating at count-1.
  - btn_down: sel_idx-1, saturating at 0.
  - Both buttons in the same cycle: ignored.
  - Either button with count==0: ignored.
- Returning to guess mode (mode 1→0): sel_idx snaps back to count-1 on the next edge.
- Buttons in guess mode: ignored.
- full and last_turn are combinational decodes of registered count; they are valid in both modes.
- A store in the same cycle as a button: the store takes precedence in guess mode; in browse mode the store is rejected and the button is processed.
- Mid-operation reset: asynchronous clear of count, sel_idx and all outputs; the first store after release writes entry 0.
- No wrap-around: once full, further stores are rejected until reset.

Decomposition:
- Package game_pkg:
  - MODE_GUESS=1'b0 and MODE_BROWSE=1'b1 constants.
  - Default peg, feedback and depth constants shared with the feedback and display blocks.
- One sub-module: history_regfile, a DEPTH x W register array with 1 synchronous write port and 1 registered read port, parametrised by DEPTH and W.
- Control (count, sel_idx, navigation, error pulse) stays in guess_history_buf.

Test Plan:
- Reset, then 3 stores with guesses 0x111, 0x222, 0x333 and feedback (1,2), (0,3), (4,0) → count=3; after the last store, one cycle later sel_idx=2, sel_guess=0x333, sel_black=4, sel_white=0.
- Browse with count=3: btn_down x3 → sel_idx 1,0,0 (saturates); btn_up x3 → 1,2,2; sel_guess tracks with 1-cycle latency.
- 8 stores → last_turn=1 after the 7th store, full=1 after the 8th; a 9th store → store_err pulses once and count stays 8.
- store while mode=1 → store_err pulse, count unchanged; btn_up and btn_down in the same cycle → sel_idx unchanged.
- Browse with count=0 → sel_valid=0, sel_*=0, buttons ignored.
- Assert reset asynchronously mid-browse with count=5 → all outputs 0 immediately; after release, one store → count=1, sel_idx=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared Mastermind datapath constants: mode encoding and default geometry used by the
// history, feedback and display blocks.
package game_pkg;

  localparam logic MODE_GUESS  = 1'b0;
  localparam logic MODE_BROWSE = 1'b1;

  localparam int unsigned NUM_PEGS_DEF = 4;
  localparam int unsigned PEG_W_DEF    = 3;
  localparam int unsigned FB_W_DEF     = 3;
  localparam int unsigned DEPTH_DEF    = 8;

endpackage

// File: rtl/history_regfile.sv
// DEPTH x W register array with one synchronous write port and one registered read port.
// Storage is not reset; only the read register is.
module history_regfile #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 18,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_clr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // rd_clr masks stale, never-written storage so the consumer sees zeros
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_clr) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/guess_history_buf.sv
// Guess/feedback history buffer: records each committed guess with its feedback and
// selects either the newest entry (guess mode) or a player-browsed entry (browse mode).
module guess_history_buf
  import game_pkg::*;
#(
  parameter int unsigned NUM_PEGS = NUM_PEGS_DEF,
  parameter int unsigned PEG_W    = PEG_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned FB_W     = FB_W_DEF,
  localparam int unsigned GW      = NUM_PEGS * PEG_W,
  localparam int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             store,
  input  logic [GW-1:0]    guess_in,
  input  logic [FB_W-1:0]  fb_black_in,
  input  logic [FB_W-1:0]  fb_white_in,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [GW-1:0]    sel_guess,
  output logic [FB_W-1:0]  sel_black,
  output logic [FB_W-1:0]  sel_white,
  output logic [IDX_W-1:0] sel_idx,
  output logic [CNT_W-1:0] count,
  output logic             sel_valid,
  output logic             full,
  output logic             last_turn,
  output logic             store_err
);

  localparam int unsigned W = GW + 2 * FB_W;

  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] count_m1;
  logic             mode_q;
  logic             sel_valid_q;
  logic             store_err_q;
  logic             is_empty, is_full;
  logic             store_ok, store_rej;
  logic             nav_up, nav_dn;
  logic [W-1:0]     wr_data, rd_data;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(DEPTH));
  assign count_m1  = count_q - CNT_W'(1);
  assign last_idx  = is_empty ? '0 : IDX_W'(count_m1);

  assign store_ok  = store && (mode == MODE_GUESS) && !is_full;
  assign store_rej = store && !store_ok;

  // Simultaneous buttons cancel; nothing to browse when empty
  assign nav_up = (mode == MODE_BROWSE) && btn_up && !btn_down && !is_empty;
  assign nav_dn = (mode == MODE_BROWSE) && btn_down && !btn_up && !is_empty;

  always_comb begin
    count_d   = count_q;
    sel_idx_d = sel_idx_q;
    if (store_ok) begin
      count_d   = count_q + CNT_W'(1);
      sel_idx_d = IDX_W'(count_q);
    end else if (mode == MODE_GUESS) begin
      sel_idx_d = last_idx;
    end else if (mode_q == MODE_GUESS) begin
      // First browse cycle starts from the newest entry
      sel_idx_d = last_idx;
    end else if (nav_up) begin
      if (sel_idx_q < last_idx) begin
        sel_idx_d = sel_idx_q + IDX_W'(1);
      end
    end else if (nav_dn) begin
      if (sel_idx_q != '0) begin
        sel_idx_d = sel_idx_q - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      sel_idx_q   <= '0;
      mode_q      <= MODE_GUESS;
      sel_valid_q <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      sel_idx_q   <= sel_idx_d;
      mode_q      <= mode;
      sel_valid_q <= !is_empty;
      store_err_q <= store_rej;
    end
  end

  assign wr_data = {guess_in, fb_black_in, fb_white_in};

  history_regfile #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (store_ok),
    .wr_addr (IDX_W'(count_q)),
    .wr_data (wr_data),
    .rd_addr (sel_idx_q),
    .rd_clr  (is_empty),
    .rd_data (rd_data)
  );

  assign sel_guess = rd_data[W-1 -: GW];
  assign sel_black = rd_data[2*FB_W-1 -: FB_W];
  assign sel_white = rd_data[FB_W-1:0];
  assign sel_idx   = sel_idx_q;
  assign count     = count_q;
  assign sel_valid = sel_valid_q;
  assign full      = is_full;
  assign last_turn = (count_q == CNT_W'(DEPTH - 1));
  assign store_err = store_err_q;

endmodule

// File: tb/tb_guess_history_buf.sv
// Directed bench for guess_history_buf: store, browse, full/last-turn, rejection and reset.
module tb_guess_history_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        store;
  logic [11:0] guess_in;
  logic [2:0]  fb_black_in;
  logic [2:0]  fb_white_in;
  logic        btn_up;
  logic        btn_down;
  logic [11:0] sel_guess;
  logic [2:0]  sel_black;
  logic [2:0]  sel_white;
  logic [2:0]  sel_idx;
  logic [3:0]  count;
  logic        sel_valid;
  logic        full;
  logic        last_turn;
  logic        store_err;

  int errors = 0;
  int checks = 0;

  guess_history_buf #(
    .NUM_PEGS (4),
    .PEG_W    (3),
    .DEPTH    (8),
    .FB_W     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .store       (store),
    .guess_in    (guess_in),
    .fb_black_in (fb_black_in),
    .fb_white_in (fb_white_in),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .sel_guess   (sel_guess),
    .sel_black   (sel_black),
    .sel_white   (sel_white),
    .sel_idx     (sel_idx),
    .count       (count),
    .sel_valid   (sel_valid),
    .full        (full),
    .last_turn   (last_turn),
    .store_err   (store_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [11:0] g, input logic [2:0] b, input logic [2:0] w);
    store = 1'b1; guess_in = g; fb_black_in = b; fb_white_in = w;
    step();
    store = 1'b0;
  endtask

  task automatic pulse(input logic up, input logic dn);
    btn_up = up; btn_down = dn;
    step();
    btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic check_entry(input string tag, input logic [11:0] g, input logic [2:0] b,
                             input logic [2:0] w);
    check({tag, "_guess"}, 32'(sel_guess), 32'(g));
    check({tag, "_black"}, 32'(sel_black), 32'(b));
    check({tag, "_white"}, 32'(sel_white), 32'(w));
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; store = 1'b0; guess_in = '0;
    fb_black_in = '0; fb_white_in = '0; btn_up = 1'b0; btn_down = 1'b0;
    step(); step();
    check("rst_count", 32'(count), 0);
    check("rst_idx", 32'(sel_idx), 0);
    check("rst_valid", 32'(sel_valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_last", 32'(last_turn), 0);
    check("rst_err", 32'(store_err), 0);
    check_entry("rst", 12'h000, 3'd0, 3'd0);
    reset = 1'b0;
    step();

    // Three stores in guess mode
    do_store(12'h111, 3'd1, 3'd2);
    check("st1_count", 32'(count), 1);
    check("st1_idx", 32'(sel_idx), 0);
    do_store(12'h222, 3'd0, 3'd3);
    do_store(12'h333, 3'd4, 3'd0);
    check("st3_count", 32'(count), 3);
    check("st3_idx", 32'(sel_idx), 2);
    step();
    check_entry("st3", 12'h333, 3'd4, 3'd0);
    check("st3_valid", 32'(sel_valid), 1);
    check("st3_err", 32'(store_err), 0);

    // Browse down three times then up three times
    mode = 1'b1;
    step();
    check("br_enter_idx", 32'(sel_idx), 2);
    pulse(1'b0, 1'b1);
    check("dn1_idx", 32'(sel_idx), 1);
    step();
    check_entry("dn1", 12'h222, 3'd0, 3'd3);
    pulse(1'b0, 1'b1);
    check("dn2_idx", 32'(sel_idx), 0);
    step();
    check_entry("dn2", 12'h111, 3'd1, 3'd2);
    pulse(1'b0, 1'b1);
    check("dn3_idx_sat", 32'(sel_idx), 0);
    pulse(1'b1, 1'b0);
    check("up1_idx", 32'(sel_idx), 1);
    step();
    check_entry("up1", 12'h222, 3'd0, 3'd3);
    pulse(1'b1, 1'b0);
    check("up2_idx", 32'(sel_idx), 2);
    step();
    check_entry("up2", 12'h333, 3'd4, 3'd0);
    pulse(1'b1, 1'b0);
    check("up3_idx_sat", 32'(sel_idx), 2);

    // Both buttons together are ignored
    pulse(1'b0, 1'b1);
    check("dn4_idx", 32'(sel_idx), 1);
    pulse(1'b1, 1'b1);
    check("both_idx", 32'(sel_idx), 1);

    // Store in browse mode is rejected while the button still acts
    store = 1'b1; guess_in = 12'h444; fb_black_in = 3'd1; fb_white_in = 3'd1;
    pulse(1'b1, 1'b0);
    store = 1'b0;
    check("brst_err", 32'(store_err), 1);
    check("brst_count", 32'(count), 3);
    check("brst_idx", 32'(sel_idx), 2);
    step();
    check("brst_err_clr", 32'(store_err), 0);

    // Buttons ignored in guess mode; index snaps to newest
    mode = 1'b0;
    pulse(1'b0, 1'b1);
    check("gm_idx", 32'(sel_idx), 2);

    // Fill to DEPTH
    do_store(12'h444, 3'd1, 3'd0);
    do_store(12'h555, 3'd2, 3'd0);
    do_store(12'h666, 3'd3, 3'd0);
    check("st6_last", 32'(last_turn), 0);
    do_store(12'h777, 3'd0, 3'd1);
    check("st7_count", 32'(count), 7);
    check("st7_last", 32'(last_turn), 1);
    check("st7_full", 32'(full), 0);
    do_store(12'habc, 3'd2, 3'd2);
    check("st8_full", 32'(full), 1);
    check("st8_last", 32'(last_turn), 0);
    check("st8_idx", 32'(sel_idx), 7);
    do_store(12'hddd, 3'd4, 3'd0);
    check("st9_err", 32'(store_err), 1);
    check("st9_count", 32'(count), 8);
    step();
    check("st9_err_clr", 32'(store_err), 0);
    check_entry("st9", 12'habc, 3'd2, 3'd2);

    // Empty browse
    reset = 1'b1;
    #1;
    reset = 1'b0;
    mode = 1'b1;
    step();
    pulse(1'b1, 1'b0);
    check("emp_up_idx", 32'(sel_idx), 0);
    pulse(1'b0, 1'b1);
    check("emp_dn_idx", 32'(sel_idx), 0);
    step();
    check("emp_valid", 32'(sel_valid), 0);
    check_entry("emp", 12'h000, 3'd0, 3'd0);

    // Mid-browse asynchronous reset with five entries
    mode = 1'b0;
    do_store(12'h101, 3'd1, 3'd0);
    do_store(12'h202, 3'd2, 3'd0);
    do_store(12'h303, 3'd3, 3'd0);
    do_store(12'h404, 3'd4, 3'd0);
    do_store(12'h505, 3'd0, 3'd4);
    mode = 1'b1;
    step();
    pulse(1'b0, 1'b1);
    step();
    check("pre_rst_count", 32'(count), 5);
    check("pre_rst_idx", 32'(sel_idx), 3);
    check_entry("pre_rst", 12'h404, 3'd4, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_idx", 32'(sel_idx), 0);
    check("arst_valid", 32'(sel_valid), 0);
    check_entry("arst", 12'h000, 3'd0, 3'd0);
    #1;
    reset = 1'b0;
    mode = 1'b0;
    step();
    do_store(12'hfed, 3'd2, 3'd1);
    check("post_count", 32'(count), 1);
    check("post_idx", 32'(sel_idx), 0);
    step();
    check_entry("post", 12'hfed, 3'd2, 3'd1);
    check("post_valid", 32'(sel_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
